// File: rtl/mcpu_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control: states, opcodes, ALU/mux selects
// and the packed control word driven onto the datapath.
package mcpu_ctrl_pkg;

    localparam int unsigned STATE_BITS = 4;
    localparam int unsigned OPCODE_W   = 6;

    typedef enum logic [STATE_BITS-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/mctrl_output_decode.sv
// Purely combinational state -> control word decode (Moore outputs, ungated).
// ADDI states decode only when MCTRL_ADDI_EN is defined.
import mcpu_ctrl_pkg::*;

module mctrl_output_decode (
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RTWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
`ifdef MCTRL_ADDI_EN
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle MIPS main control FSM: state register, opcode-driven sequencing, mem_ready
// gating of fetch writes and reset masking. Optional addi support via MCTRL_ADDI_EN.
import mcpu_ctrl_pkg::*;

module multicycle_main_control #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    state_t state_q;
    state_t state_d;
    logic   op_legal;
    ctrl_t  ctrl_raw;
    ctrl_t  ctrl_out;
    logic   illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state sequencing; memory states hold until mem_ready
    always_comb begin
        state_d  = S_FETCH;
        op_legal = 1'b1;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MCTRL_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    default: begin
                        state_d  = S_FETCH;
                        op_legal = 1'b0;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_RTWB;
            S_RTWB:   state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
`ifdef MCTRL_ADDI_EN
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    mctrl_output_decode u_decode (
        .state (state_q),
        .ctrl  (ctrl_raw)
    );

    // Fetch writes wait for the instruction word; reset forces everything low at once
    always_comb begin
        ctrl_out = ctrl_raw;
        illegal  = (state_q == S_DECODE) && !op_legal;
        if (state_q == S_FETCH) begin
            ctrl_out.pc_write = ctrl_raw.pc_write & mem_ready;
            ctrl_out.ir_write = ctrl_raw.ir_write & mem_ready;
        end
        if (reset) begin
            ctrl_out = '0;
            illegal  = 1'b0;
        end
    end

    assign PCWrite     = ctrl_out.pc_write;
    assign PCWriteCond = ctrl_out.pc_write_cond;
    assign IorD        = ctrl_out.i_or_d;
    assign MemRead     = ctrl_out.mem_read;
    assign MemWrite    = ctrl_out.mem_write;
    assign IRWrite     = ctrl_out.ir_write;
    assign MemtoReg    = ctrl_out.mem_to_reg;
    assign RegDst      = ctrl_out.reg_dst;
    assign RegWrite    = ctrl_out.reg_write;
    assign ALUSrcA     = ctrl_out.alu_src_a;
    assign ALUSrcB     = ctrl_out.alu_src_b;
    assign ALUOp       = ctrl_out.alu_op;
    assign PCSource    = ctrl_out.pc_source;
    assign illegal_op  = illegal;
    assign state       = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control: instruction-level reference model pushes the
// expected per-cycle control word; a monitor pops and compares. Honours MCTRL_ADDI_EN.
module tb_multicycle_main_control;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       pcwc;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       m2r;
        logic       rdst;
        logic       rw;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       ill;
    } word_t;

    typedef struct {
        word_t w;
        string tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    multicycle_main_control #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    function automatic bit legal(input logic [5:0] op);
        bit ok;
        ok = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
             (op == 6'b000100) || (op == 6'b000010);
`ifdef MCTRL_ADDI_EN
        ok = ok || (op == 6'b001000);
`endif
        return ok;
    endfunction

    // Control word listed for each numbered step of an instruction
    function automatic word_t spec_word(input int st, input bit mr);
        word_t w;
        w = '0;
        w.st = 4'(st);
        case (st)
            0:  begin w.mrd = 1; w.srcb = 2'b01; w.pcw = mr; w.irw = mr; end
            1:  w.srcb = 2'b11;
            2:  begin w.srca = 1; w.srcb = 2'b10; end
            3:  begin w.mrd = 1; w.iord = 1; end
            4:  begin w.rw = 1; w.m2r = 1; end
            5:  begin w.mwr = 1; w.iord = 1; end
            6:  begin w.srca = 1; w.aluop = 2'b10; end
            7:  begin w.rw = 1; w.rdst = 1; end
            8:  begin w.srca = 1; w.aluop = 2'b01; w.pcwc = 1; w.pcsrc = 2'b01; end
            9:  begin w.pcw = 1; w.pcsrc = 2'b10; end
            10: begin w.srca = 1; w.srcb = 2'b10; end
            11: w.rw = 1;
            default: w = '0;
        endcase
        return w;
    endfunction

    task automatic cyc(input bit rst, input bit mr, input logic [5:0] op,
                       input word_t w, input string tag);
        exp_t e;
        @(negedge clk);
        reset     = rst;
        mem_ready = mr;
        opcode    = op;
        e.w   = w;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // One whole instruction: fetch (with waits), decode, then the opcode's step list
    task automatic issue(input logic [5:0] op, input int fwait, input int mwait,
                         input string tag);
        int    steps[$];
        word_t w;
        for (int i = 0; i < fwait; i++) cyc(1'b0, 1'b0, op, spec_word(0, 1'b0), tag);
        cyc(1'b0, 1'b1, op, spec_word(0, 1'b1), tag);
        w = spec_word(1, 1'b0);
        w.ill = !legal(op);
        cyc(1'b0, 1'($urandom), op, w, tag);
        if (legal(op)) begin
            case (op)
                6'b100011: steps = '{2, 3, 4};
                6'b101011: steps = '{2, 5};
                6'b000000: steps = '{6, 7};
                6'b000100: steps = '{8};
                6'b000010: steps = '{9};
                default:   steps = '{10, 11};
            endcase
        end
        foreach (steps[k]) begin
            if (steps[k] == 3 || steps[k] == 5) begin
                for (int i = 0; i < mwait; i++) cyc(1'b0, 1'b0, op, spec_word(steps[k], 1'b0), tag);
                cyc(1'b0, 1'b1, op, spec_word(steps[k], 1'b1), tag);
            end else begin
                cyc(1'b0, 1'($urandom), op, spec_word(steps[k], 1'b0), tag);
            end
        end
    endtask

    // Monitor: compare just before each rising edge
    always @(negedge clk) begin
        exp_t  e;
        word_t act;
        #4;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            act = '{st: state, pcw: PCWrite, pcwc: PCWriteCond, iord: IorD, mrd: MemRead,
                    mwr: MemWrite, irw: IRWrite, m2r: MemtoReg, rdst: RegDst, rw: RegWrite,
                    srca: ALUSrcA, srcb: ALUSrcB, aluop: ALUOp, pcsrc: PCSource,
                    ill: illegal_op};
            n_checks++;
            if (act !== e.w) begin
                n_fail++;
                $display("FAIL %s @%0t: got st=%0d word=%h, want st=%0d word=%h",
                         e.tag, $time, act.st, act, e.w.st, e.w);
            end
        end
    end

    initial begin
        logic [5:0] legal_ops[6];
        logic [5:0] op;
        legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};

        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 6'b100011, '0, "reset_hold");
        issue(6'b100011, 0, 0, "lw");
        issue(6'b000000, 0, 0, "rtype");
        issue(6'b000100, 0, 0, "beq");
        issue(6'b101011, 0, 4, "sw_wait");
        issue(6'b111111, 0, 0, "illegal");
        issue(6'b000010, 2, 0, "j_fetchwait");

        // reset during a stalled load
        cyc(1'b0, 1'b1, 6'b100011, spec_word(0, 1'b1), "rst_mid");
        cyc(1'b0, 1'b0, 6'b100011, spec_word(1, 1'b0), "rst_mid");
        cyc(1'b0, 1'b0, 6'b100011, spec_word(2, 1'b0), "rst_mid");
        cyc(1'b0, 1'b0, 6'b100011, spec_word(3, 1'b0), "rst_mid");
        cyc(1'b1, 1'b0, 6'b100011, '0, "rst_mid_zero");
        cyc(1'b1, 1'b0, 6'b100011, '0, "rst_mid_zero");
        issue(6'b100011, 0, 1, "after_rst");

        issue(6'b001000, 0, 0, "addi");

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) < 7) op = legal_ops[$urandom_range(0, 5)];
            else                           op = 6'($urandom);
            issue(op, $urandom_range(0, 2), $urandom_range(0, 3), "random");
        end

        @(negedge clk);
        #6;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
